// File: rtl/treq_nwr_sink.sv
// Target-side SRIO write sink: NWRITE/NWRITE_R/SWRITE payload goes to a RAM write port, all other
// treq packets pass through on fwd_*. Optional macro NWR_SINK_LEN_CHECK_EN adds payload length checking.
module treq_nwr_sink #(
    parameter int unsigned RAM_ADDR_WIDTH = 10,
    parameter int unsigned DATA_WIDTH     = 64
) (
    input  logic                      log_clk,
    input  logic                      log_rst,

    input  logic                      treq_tvalid_in,
    output logic                      treq_tready_o,
    input  logic                      treq_tlast_in,
    input  logic [DATA_WIDTH-1:0]     treq_tdata_in,
    input  logic [DATA_WIDTH/8-1:0]   treq_tkeep_in,
    input  logic [31:0]               treq_tuser_in,

    output logic                      fwd_tvalid_o,
    input  logic                      fwd_tready_in,
    output logic                      fwd_tlast_o,
    output logic [DATA_WIDTH-1:0]     fwd_tdata_o,
    output logic [DATA_WIDTH/8-1:0]   fwd_tkeep_o,
    output logic [31:0]               fwd_tuser_o,

    output logic                      ram_wr_en_o,
    output logic [RAM_ADDR_WIDTH-1:0] ram_wr_addr_o,
    output logic [DATA_WIDTH-1:0]     ram_wr_data_o,
    output logic [DATA_WIDTH/8-1:0]   ram_wr_be_o,

    output logic                      nwr_done_o,
    input  logic                      nwr_done_ack_in,
    output logic [33:0]               nwr_addr_o,
    output logic [8:0]                nwr_bytes_o,
    output logic [15:0]               nwr_src_id_o,
    output logic                      nwr_err_o,
    output logic [15:0]               nwr_pkt_cnt_o
);

    typedef enum logic [1:0] {
        StIdle,
        StWrData,
        StFwd,
        StDone
    } state_e;

    state_e                    state_q;
    logic [RAM_ADDR_WIDTH-1:0] ptr_q;
    logic                      ram_wr_en_q;
    logic [RAM_ADDR_WIDTH-1:0] ram_wr_addr_q;
    logic [DATA_WIDTH-1:0]     ram_wr_data_q;
    logic [DATA_WIDTH/8-1:0]   ram_wr_be_q;
    logic [33:0]               addr_q;
    logic [8:0]                bytes_q;
    logic [15:0]               src_id_q;
    logic                      err_q;
    logic [15:0]               pkt_cnt_q;

    logic [3:0]                hdr_ftype;
    logic [3:0]                hdr_ttype;
    logic [7:0]                hdr_size;
    logic [33:0]               hdr_addr;
    logic                      hdr_is_wr;

    assign hdr_ftype = treq_tdata_in[55:52];
    assign hdr_ttype = treq_tdata_in[51:48];
    assign hdr_size  = treq_tdata_in[43:36];
    assign hdr_addr  = treq_tdata_in[33:0];

    // FTYPE 5 with TTYPE 4/5 is NWRITE/NWRITE_R; FTYPE 6 is SWRITE
    assign hdr_is_wr = ((hdr_ftype == 4'd5) && ((hdr_ttype == 4'd4) || (hdr_ttype == 4'd5)))
                     || (hdr_ftype == 4'd6);

    logic unused_hdr_bits;
    assign unused_hdr_bits = ^{treq_tdata_in[63:56], treq_tdata_in[47:44],
                               treq_tdata_in[35:34], treq_tuser_in[15:0]};

`ifdef NWR_SINK_LEN_CHECK_EN
    logic [5:0] beat_cnt_q;
    logic [5:0] exp_beats_q;
    logic [5:0] beat_cnt_nxt;

    // Saturates well above the 32-beat maximum so overruns always mismatch
    assign beat_cnt_nxt = (beat_cnt_q == 6'h3f) ? 6'h3f : beat_cnt_q + 6'd1;
`endif

    always_comb begin
        treq_tready_o = 1'b0;
        fwd_tvalid_o  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (treq_tvalid_in) begin
                    if (hdr_is_wr) begin
                        treq_tready_o = 1'b1;
                    end else begin
                        fwd_tvalid_o  = 1'b1;
                        treq_tready_o = fwd_tready_in;
                    end
                end
            end
            StWrData: begin
                treq_tready_o = 1'b1;
            end
            StFwd: begin
                fwd_tvalid_o  = treq_tvalid_in;
                treq_tready_o = fwd_tready_in;
            end
            StDone: begin
                treq_tready_o = 1'b0;
            end
        endcase
    end

    assign fwd_tlast_o = treq_tlast_in;
    assign fwd_tdata_o = treq_tdata_in;
    assign fwd_tkeep_o = treq_tkeep_in;
    assign fwd_tuser_o = treq_tuser_in;

    always_ff @(posedge log_clk) begin
        if (log_rst) begin
            state_q       <= StIdle;
            ptr_q         <= '0;
            ram_wr_en_q   <= 1'b0;
            ram_wr_addr_q <= '0;
            ram_wr_data_q <= '0;
            ram_wr_be_q   <= '0;
            addr_q        <= '0;
            bytes_q       <= '0;
            src_id_q      <= '0;
            err_q         <= 1'b0;
            pkt_cnt_q     <= '0;
`ifdef NWR_SINK_LEN_CHECK_EN
            beat_cnt_q    <= '0;
            exp_beats_q   <= '0;
`endif
        end else begin
            ram_wr_en_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (treq_tvalid_in) begin
                        if (hdr_is_wr) begin
                            addr_q   <= hdr_addr;
                            bytes_q  <= {1'b0, hdr_size} + 9'd1;
                            src_id_q <= treq_tuser_in[31:16];
                            ptr_q    <= hdr_addr[RAM_ADDR_WIDTH+2:3];
`ifdef NWR_SINK_LEN_CHECK_EN
                            beat_cnt_q  <= '0;
                            exp_beats_q <= {1'b0, hdr_size[7:3]} + 6'd1;
`endif
                            if (treq_tlast_in) begin
                                err_q   <= 1'b1;
                                state_q <= StDone;
                            end else begin
                                err_q   <= 1'b0;
                                state_q <= StWrData;
                            end
                        end else if (fwd_tready_in && !treq_tlast_in) begin
                            state_q <= StFwd;
                        end
                    end
                end
                StWrData: begin
                    if (treq_tvalid_in) begin
                        ram_wr_addr_q <= ptr_q;
                        ram_wr_data_q <= treq_tdata_in;
                        ram_wr_be_q   <= treq_tkeep_in;
                        ptr_q         <= ptr_q + RAM_ADDR_WIDTH'(1);
`ifdef NWR_SINK_LEN_CHECK_EN
                        ram_wr_en_q <= (beat_cnt_q < exp_beats_q);
                        beat_cnt_q  <= beat_cnt_nxt;
                        if (treq_tlast_in) begin
                            err_q <= (beat_cnt_nxt != exp_beats_q);
                        end
`else
                        ram_wr_en_q <= 1'b1;
`endif
                        if (treq_tlast_in) begin
                            state_q <= StDone;
                        end
                    end
                end
                StFwd: begin
                    if (treq_tvalid_in && fwd_tready_in && treq_tlast_in) begin
                        state_q <= StIdle;
                    end
                end
                StDone: begin
                    if (nwr_done_ack_in) begin
                        pkt_cnt_q <= pkt_cnt_q + 16'd1;
                        state_q   <= StIdle;
                    end
                end
            endcase
        end
    end

    assign ram_wr_en_o   = ram_wr_en_q;
    assign ram_wr_addr_o = ram_wr_addr_q;
    assign ram_wr_data_o = ram_wr_data_q;
    assign ram_wr_be_o   = ram_wr_be_q;

    assign nwr_done_o    = (state_q == StDone);
    assign nwr_addr_o    = addr_q;
    assign nwr_bytes_o   = bytes_q;
    assign nwr_src_id_o  = src_id_q;
    assign nwr_err_o     = err_q;
    assign nwr_pkt_cnt_o = pkt_cnt_q;

endmodule

// File: tb/tb_treq_nwr_sink.sv
// Scoreboard bench for treq_nwr_sink: expected RAM writes, completions and forwarded beats are
// queued when stimulus is driven and compared as the DUT produces them.
module tb_treq_nwr_sink;

    localparam int AW = 10;

    typedef struct packed {
        logic [AW-1:0] a;
        logic [63:0]   d;
        logic [7:0]    be;
    } ram_exp_t;

    typedef struct packed {
        logic [33:0] addr;
        logic [8:0]  bytes;
        logic [15:0] src;
        logic        err;
    } done_exp_t;

    typedef struct packed {
        logic [63:0] d;
        logic [7:0]  k;
        logic [31:0] u;
        logic        l;
    } fwd_exp_t;

    logic          log_clk = 1'b0;
    logic          log_rst = 1'b1;
    logic          treq_tvalid_in = 1'b0;
    logic          treq_tready_o;
    logic          treq_tlast_in = 1'b0;
    logic [63:0]   treq_tdata_in = '0;
    logic [7:0]    treq_tkeep_in = '0;
    logic [31:0]   treq_tuser_in = '0;
    logic          fwd_tvalid_o;
    logic          fwd_tready_in;
    logic          fwd_tlast_o;
    logic [63:0]   fwd_tdata_o;
    logic [7:0]    fwd_tkeep_o;
    logic [31:0]   fwd_tuser_o;
    logic          ram_wr_en_o;
    logic [AW-1:0] ram_wr_addr_o;
    logic [63:0]   ram_wr_data_o;
    logic [7:0]    ram_wr_be_o;
    logic          nwr_done_o;
    logic          nwr_done_ack_in;
    logic [33:0]   nwr_addr_o;
    logic [8:0]    nwr_bytes_o;
    logic [15:0]   nwr_src_id_o;
    logic          nwr_err_o;
    logic [15:0]   nwr_pkt_cnt_o;

    logic ack_en = 1'b1;
    logic tog_en = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;
    int   exp_cnt = 0;

    ram_exp_t  ram_q[$];
    done_exp_t done_q[$];
    fwd_exp_t  fwd_q[$];

    treq_nwr_sink #(
        .RAM_ADDR_WIDTH(AW),
        .DATA_WIDTH    (64)
    ) dut (
        .log_clk        (log_clk),
        .log_rst        (log_rst),
        .treq_tvalid_in (treq_tvalid_in),
        .treq_tready_o  (treq_tready_o),
        .treq_tlast_in  (treq_tlast_in),
        .treq_tdata_in  (treq_tdata_in),
        .treq_tkeep_in  (treq_tkeep_in),
        .treq_tuser_in  (treq_tuser_in),
        .fwd_tvalid_o   (fwd_tvalid_o),
        .fwd_tready_in  (fwd_tready_in),
        .fwd_tlast_o    (fwd_tlast_o),
        .fwd_tdata_o    (fwd_tdata_o),
        .fwd_tkeep_o    (fwd_tkeep_o),
        .fwd_tuser_o    (fwd_tuser_o),
        .ram_wr_en_o    (ram_wr_en_o),
        .ram_wr_addr_o  (ram_wr_addr_o),
        .ram_wr_data_o  (ram_wr_data_o),
        .ram_wr_be_o    (ram_wr_be_o),
        .nwr_done_o     (nwr_done_o),
        .nwr_done_ack_in(nwr_done_ack_in),
        .nwr_addr_o     (nwr_addr_o),
        .nwr_bytes_o    (nwr_bytes_o),
        .nwr_src_id_o   (nwr_src_id_o),
        .nwr_err_o      (nwr_err_o),
        .nwr_pkt_cnt_o  (nwr_pkt_cnt_o)
    );

    always #5 log_clk = ~log_clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] hdr(input logic [7:0] tid, input logic [3:0] ft,
                                        input logic [3:0] tt, input logic [7:0] size,
                                        input logic [33:0] addr);
        return {tid, ft, tt, 4'h0, size, 2'b00, addr};
    endfunction

    task automatic idle(input int n);
        repeat (n) @(posedge log_clk);
        #1;
    endtask

    // Holds one beat until it transfers; called and returns at posedge+1.
    task automatic drive_beat(input logic [63:0] d, input logic [7:0] k, input logic [31:0] u,
                              input logic l);
        int n;
        n = 0;
        treq_tvalid_in = 1'b1;
        treq_tdata_in  = d;
        treq_tkeep_in  = k;
        treq_tuser_in  = u;
        treq_tlast_in  = l;
        @(negedge log_clk);
        while (!treq_tready_o && n < 200) begin
            n++;
            @(negedge log_clk);
        end
        if (n >= 200) check_eq("beat_accept_timeout", {63'b0, treq_tready_o}, 64'd1);
        @(posedge log_clk);
        #1;
        treq_tvalid_in = 1'b0;
        treq_tlast_in  = 1'b0;
    endtask

    task automatic send_wr(input logic [3:0] ft, input logic [3:0] tt, input logic [33:0] addr,
                           input logic [7:0] size, input logic [15:0] src, input int nbeats,
                           input logic [63:0] base, input logic [7:0] keep);
        int        expb;
        logic      wr_ok;
        ram_exp_t  r;
        done_exp_t d;
        logic [AW-1:0] w;
        expb = int'(size[7:3]) + 1;
        w = addr[AW+2:3];
        for (int i = 0; i < nbeats; i++) begin
            wr_ok = 1'b1;
`ifdef NWR_SINK_LEN_CHECK_EN
            wr_ok = (i < expb);
`endif
            if (wr_ok) begin
                r.a  = w;
                r.d  = base + 64'(i);
                r.be = keep;
                ram_q.push_back(r);
            end
            w = w + AW'(1);
        end
        d.addr  = addr;
        d.bytes = {1'b0, size} + 9'd1;
        d.src   = src;
        d.err   = (nbeats == 0);
`ifdef NWR_SINK_LEN_CHECK_EN
        if (nbeats != 0 && nbeats != expb) d.err = 1'b1;
`endif
        done_q.push_back(d);
        drive_beat(hdr(8'h11, ft, tt, size, addr), 8'hff, {src, 16'h00ab}, nbeats == 0);
        for (int i = 0; i < nbeats; i++) begin
            drive_beat(base + 64'(i), keep, {src, 16'h00ab}, i == nbeats - 1);
        end
    endtask

    task automatic push_fwd(input logic [63:0] d, input logic [7:0] k, input logic [31:0] u,
                            input logic l);
        fwd_exp_t f;
        f.d = d;
        f.k = k;
        f.u = u;
        f.l = l;
        fwd_q.push_back(f);
    endtask

    task automatic check_reset_vals(input string pfx);
        check_eq({pfx, "_tready"}, treq_tready_o, 0);
        check_eq({pfx, "_fwd_tvalid"}, fwd_tvalid_o, 0);
        check_eq({pfx, "_ram_wr_en"}, ram_wr_en_o, 0);
        check_eq({pfx, "_ram_wr_addr"}, ram_wr_addr_o, 0);
        check_eq({pfx, "_done"}, nwr_done_o, 0);
        check_eq({pfx, "_err"}, nwr_err_o, 0);
        check_eq({pfx, "_cnt"}, nwr_pkt_cnt_o, 0);
        check_eq({pfx, "_addr"}, nwr_addr_o, 0);
        check_eq({pfx, "_bytes"}, nwr_bytes_o, 0);
        check_eq({pfx, "_src"}, nwr_src_id_o, 0);
    endtask

    initial begin
        nwr_done_ack_in = 1'b0;
        forever begin
            @(posedge log_clk);
            #1;
            nwr_done_ack_in = ack_en;
        end
    end

    initial begin
        fwd_tready_in = 1'b1;
        forever begin
            @(posedge log_clk);
            #1;
            fwd_tready_in = tog_en ? ~fwd_tready_in : 1'b1;
        end
    end

    initial begin : ram_mon
        ram_exp_t e;
        forever begin
            @(negedge log_clk);
            if (ram_wr_en_o) begin
                if (ram_q.size() == 0) begin
                    check_eq("ram_wr_unexpected", ram_wr_en_o, 0);
                end else begin
                    e = ram_q.pop_front();
                    check_eq("ram_addr", ram_wr_addr_o, e.a);
                    check_eq("ram_data", ram_wr_data_o, e.d);
                    check_eq("ram_be", ram_wr_be_o, e.be);
                end
            end
        end
    end

    initial begin : done_mon
        done_exp_t e;
        logic prev;
        prev = 1'b0;
        forever begin
            @(negedge log_clk);
            if (nwr_done_o && !prev) begin
                if (done_q.size() == 0) begin
                    check_eq("done_unexpected", nwr_done_o, 0);
                end else begin
                    e = done_q.pop_front();
                    check_eq("done_addr", nwr_addr_o, e.addr);
                    check_eq("done_bytes", nwr_bytes_o, e.bytes);
                    check_eq("done_src", nwr_src_id_o, e.src);
                    check_eq("done_err", nwr_err_o, e.err);
                    check_eq("done_cnt_before_ack", nwr_pkt_cnt_o, 16'(exp_cnt));
                    exp_cnt++;
                end
            end
            prev = nwr_done_o;
        end
    end

    initial begin : fwd_mon
        fwd_exp_t e;
        forever begin
            @(negedge log_clk);
            if (fwd_tvalid_o && fwd_tready_in) begin
                if (fwd_q.size() == 0) begin
                    check_eq("fwd_unexpected", fwd_tvalid_o, 0);
                end else begin
                    e = fwd_q.pop_front();
                    check_eq("fwd_data", fwd_tdata_o, e.d);
                    check_eq("fwd_keep_user_last", {fwd_tkeep_o, fwd_tuser_o, fwd_tlast_o},
                             {e.k, e.u, e.l});
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no end of test, expected finish within 200us");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [63:0] hb;
        idle(3);
        log_rst = 1'b0;
        @(negedge log_clk);
        check_reset_vals("rst0");
        idle(1);

        // NWRITE 0x100, 64 bytes, data 0..7
        send_wr(4'd5, 4'd4, 34'h100, 8'd63, 16'h0001, 8, 64'd0, 8'hff);
        idle(4);
        check_eq("cnt_after_first", nwr_pkt_cnt_o, 16'd1);

        // Doorbell with a toggling downstream ready
        tog_en = 1'b1;
        idle(1);
        hb = hdr(8'h22, 4'hA, 4'h0, 8'h00, 34'h0_1234_5678);
        push_fwd(hb, 8'hff, 32'h0007_0001, 1'b1);
        drive_beat(hb, 8'hff, 32'h0007_0001, 1'b1);
        tog_en = 1'b0;
        idle(3);

        // NWRITE-typed FTYPE with a non-write TTYPE: 3-beat forward through FWD state
        hb = hdr(8'h23, 4'd5, 4'hC, 8'd15, 34'h40);
        push_fwd(hb, 8'hff, 32'h0009_0001, 1'b0);
        push_fwd(64'hdead_beef_0000_0001, 8'h0f, 32'h0009_0001, 1'b0);
        push_fwd(64'hdead_beef_0000_0002, 8'hf0, 32'h0009_0001, 1'b1);
        drive_beat(hb, 8'hff, 32'h0009_0001, 1'b0);
        drive_beat(64'hdead_beef_0000_0001, 8'h0f, 32'h0009_0001, 1'b0);
        drive_beat(64'hdead_beef_0000_0002, 8'hf0, 32'h0009_0001, 1'b1);
        idle(2);

        // Completion held without ack while a second write header waits
        ack_en = 1'b0;
        idle(2);
        send_wr(4'd5, 4'd5, 34'h300, 8'd15, 16'h0005, 2, 64'h100, 8'hff);
        treq_tvalid_in = 1'b1;
        treq_tdata_in  = hdr(8'h24, 4'd5, 4'd4, 8'd7, 34'h500);
        treq_tkeep_in  = 8'hff;
        treq_tuser_in  = 32'h0006_00ab;
        treq_tlast_in  = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge log_clk);
            check_eq("hold_tready", treq_tready_o, 0);
            check_eq("hold_done", nwr_done_o, 1);
            check_eq("hold_addr", nwr_addr_o, 34'h300);
        end
        @(posedge log_clk);
        #1;
        ack_en = 1'b1;
        send_wr(4'd5, 4'd4, 34'h500, 8'd7, 16'h0006, 1, 64'h200, 8'hff);
        idle(3);

        // Word pointer wrap from 1023 to 0
        send_wr(4'd5, 4'd4, 34'(1023 * 8), 8'd15, 16'h0007, 2, 64'h300, 8'hff);
        idle(2);

        // SIZE=31 with only 3 beats: flagged only when the length check is built in
        send_wr(4'd5, 4'd4, 34'h800, 8'd31, 16'h0008, 3, 64'h400, 8'hff);
        idle(2);

        // Header-only write reports an error
        send_wr(4'd5, 4'd4, 34'h900, 8'd7, 16'h0009, 0, 64'h0, 8'hff);
        idle(2);

        // SWRITE, low address bits ignored for RAM, partial byte lanes
        send_wr(4'd6, 4'd0, 34'h3_0000_0405, 8'd7, 16'h000a, 1, 64'h0123_4567_89ab_cdef, 8'h0f);
        idle(3);
        check_eq("cnt_before_reset", nwr_pkt_cnt_o, 16'(exp_cnt));

        // Reset during beat 3 of an 8-beat write
        for (int i = 0; i < 2; i++) begin
            ram_exp_t r;
            r.a  = AW'(10'h40 + i);
            r.d  = 64'h500 + 64'(i);
            r.be = 8'hff;
            ram_q.push_back(r);
        end
        drive_beat(hdr(8'h25, 4'd5, 4'd4, 8'd63, 34'h200), 8'hff, 32'h0003_00ab, 1'b0);
        drive_beat(64'h500, 8'hff, 32'h0003_00ab, 1'b0);
        drive_beat(64'h501, 8'hff, 32'h0003_00ab, 1'b0);
        treq_tvalid_in = 1'b1;
        treq_tdata_in  = 64'h502;
        log_rst        = 1'b1;
        @(posedge log_clk);
        #1;
        log_rst        = 1'b0;
        treq_tvalid_in = 1'b0;
        exp_cnt        = 0;
        @(negedge log_clk);
        check_reset_vals("rst_mid");
        idle(2);

        send_wr(4'd5, 4'd4, 34'h100, 8'd23, 16'h000b, 3, 64'h600, 8'hff);
        idle(4);
        check_eq("cnt_final", nwr_pkt_cnt_o, 16'(exp_cnt));
        check_eq("ram_q_left", 64'(ram_q.size()), 0);
        check_eq("done_q_left", 64'(done_q.size()), 0);
        check_eq("fwd_q_left", 64'(fwd_q.size()), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
